// File: rtl/muxr4_pkg.sv
// rtl/muxr4_pkg.sv - select type and source encodings for the registered 4:1 mux
package muxr4_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_A = 2'b00;
  localparam sel_t SEL_B = 2'b01;
  localparam sel_t SEL_C = 2'b10;
  localparam sel_t SEL_D = 2'b11;

  localparam sel_t SEL_RESET = SEL_A;

endpackage

// File: rtl/mux4_core.sv
// rtl/mux4_core.sv - combinational 4:1 selection, every bit steered by the same select
module mux4_core
  import muxr4_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  sel_t             sel,
  output logic [WIDTH-1:0] y_comb
);

  always_comb begin
    y_comb = a;
    case (sel)
      SEL_A:   y_comb = a;
      SEL_B:   y_comb = b;
      SEL_C:   y_comb = c;
      SEL_D:   y_comb = d;
      default: y_comb = a;
    endcase
  end

endmodule

// File: rtl/muxr4.sv
// rtl/muxr4.sv - registered 4:1 mux with registered select and select-change flag
module muxr4
  import muxr4_pkg::*;
#(
  parameter int WIDTH = 1
) (
  output logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic             s1,
  input  logic             s2,
  input  logic             clk,
  input  logic             rst_n,
  output logic [1:0]       sel_q,
  output logic             sel_chg
);

  sel_t             w_sel;
  logic [WIDTH-1:0] w_y_comb;
  logic             w_sel_diff;

  logic [WIDTH-1:0] r_y;
  sel_t             r_sel_q;
  logic             r_sel_chg;

  assign w_sel      = {s2, s1};
  assign w_sel_diff = (w_sel != r_sel_q);

  mux4_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a      (a),
    .b      (b),
    .c      (c),
    .d      (d),
    .sel    (w_sel),
    .y_comb (w_y_comb)
  );

  // Change is judged against the select that produced the current y, so the
  // first edge after reset compares against the reset encoding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y       <= '0;
      r_sel_q   <= SEL_RESET;
      r_sel_chg <= 1'b0;
    end else begin
      r_y       <= w_y_comb;
      r_sel_q   <= w_sel;
      r_sel_chg <= w_sel_diff;
    end
  end

  assign y       = r_y;
  assign sel_q   = r_sel_q;
  assign sel_chg = r_sel_chg;

endmodule

// File: tb/tb_muxr4.sv
// tb/tb_muxr4.sv - directed self-checking bench for muxr4 at WIDTH 1 and WIDTH 8
module tb_muxr4;

  logic       clk;
  logic       rst_n;
  logic       s1;
  logic       s2;

  logic       a1, b1, c1, d1;
  logic       y1;
  logic [1:0] sq1;
  logic       chg1;

  logic [7:0] a8, b8, c8, d8;
  logic [7:0] y8;
  logic [1:0] sq8;
  logic       chg8;

  int checks;
  int errors;

  muxr4 #(.WIDTH(1)) u_dut1 (
    .y       (y1),
    .a       (a1),
    .b       (b1),
    .c       (c1),
    .d       (d1),
    .s1      (s1),
    .s2      (s2),
    .clk     (clk),
    .rst_n   (rst_n),
    .sel_q   (sq1),
    .sel_chg (chg1)
  );

  muxr4 #(.WIDTH(8)) u_dut8 (
    .y       (y8),
    .a       (a8),
    .b       (b8),
    .c       (c8),
    .d       (d8),
    .s1      (s1),
    .s2      (s2),
    .clk     (clk),
    .rst_n   (rst_n),
    .sel_q   (sq8),
    .sel_chg (chg8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic drive_sel(input logic [1:0] v);
    {s2, s1} = v;
  endtask

  task automatic edge_then_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; d1 = 1'b1;
    a8 = 8'hFF; b8 = 8'hFF; c8 = 8'hFF; d8 = 8'hFF;
    drive_sel(2'b11);
    #2;
    checks++; if (y1 !== 1'b0) begin errors++; $display("FAIL reset_y1 got %b want 0", y1); end
    checks++; if (sq1 !== 2'b00) begin errors++; $display("FAIL reset_selq got %b want 00", sq1); end
    checks++; if (chg1 !== 1'b0) begin errors++; $display("FAIL reset_chg got %b want 0", chg1); end
    checks++; if (y8 !== 8'h00) begin errors++; $display("FAIL reset_y8 got %h want 00", y8); end
  endtask

  task automatic test_first_edge_after_reset();
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b0; c1 = 1'b0; d1 = 1'b0;
    drive_sel(2'b00);
    rst_n = 1'b1;
    edge_then_sample();
    checks++; if (y1 !== 1'b1) begin errors++; $display("FAIL first_y got %b want 1", y1); end
    checks++; if (chg1 !== 1'b0) begin errors++; $display("FAIL first_chg got %b want 0", chg1); end
  endtask

  task automatic test_sweep();
    logic [1:0] sels  [4];
    logic       exp_y [4];
    sels  = '{2'b00, 2'b01, 2'b10, 2'b11};
    exp_y = '{1'b1, 1'b0, 1'b1, 1'b0};
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b0; c1 = 1'b1; d1 = 1'b0;
    drive_sel(2'b11);
    edge_then_sample();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_sel(sels[i]);
      edge_then_sample();
      checks++; if (y1 !== exp_y[i]) begin errors++; $display("FAIL sweep_y[%0d] got %b want %b", i, y1, exp_y[i]); end
      checks++; if (sq1 !== sels[i]) begin errors++; $display("FAIL sweep_selq[%0d] got %b want %b", i, sq1, sels[i]); end
      checks++; if (chg1 !== 1'b1) begin errors++; $display("FAIL sweep_chg[%0d] got %b want 1", i, chg1); end
    end
  endtask

  task automatic test_data_toggle();
    logic cv;
    @(negedge clk);
    drive_sel(2'b10);
    c1 = 1'b0;
    edge_then_sample();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cv = (i % 2 == 0);
      c1 = cv;
      a1 = ~cv; b1 = ~cv; d1 = ~cv;
      edge_then_sample();
      checks++; if (y1 !== cv) begin errors++; $display("FAIL toggle_y[%0d] got %b want %b", i, y1, cv); end
      checks++; if (chg1 !== 1'b0) begin errors++; $display("FAIL toggle_chg[%0d] got %b want 0", i, chg1); end
    end
  endtask

  task automatic test_mid_edge();
    @(negedge clk);
    a1 = 1'b0; d1 = 1'b1;
    drive_sel(2'b00);
    edge_then_sample();
    checks++; if (y1 !== 1'b0) begin errors++; $display("FAIL mid_pre_y got %b want 0", y1); end
    @(negedge clk);
    drive_sel(2'b11);
    #2;
    checks++; if (y1 !== 1'b0) begin errors++; $display("FAIL mid_hold_y got %b want 0", y1); end
    edge_then_sample();
    checks++; if (y1 !== 1'b1) begin errors++; $display("FAIL mid_post_y got %b want 1", y1); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (y1 !== 1'b0) begin errors++; $display("FAIL areset_y got %b want 0", y1); end
    checks++; if (sq1 !== 2'b00) begin errors++; $display("FAIL areset_selq got %b want 00", sq1); end
    checks++; if (chg1 !== 1'b0) begin errors++; $display("FAIL areset_chg got %b want 0", chg1); end
    @(negedge clk);
    drive_sel(2'b01);
    b1 = 1'b1;
    rst_n = 1'b1;
    edge_then_sample();
    checks++; if (y1 !== 1'b1) begin errors++; $display("FAIL arel_y got %b want 1", y1); end
    checks++; if (chg1 !== 1'b1) begin errors++; $display("FAIL arel_chg got %b want 1", chg1); end
    checks++; if (sq1 !== 2'b01) begin errors++; $display("FAIL arel_selq got %b want 01", sq1); end
  endtask

  task automatic test_wide();
    @(negedge clk);
    a8 = 8'h11; b8 = 8'h22; c8 = 8'h44; d8 = 8'h88;
    drive_sel(2'b11);
    edge_then_sample();
    checks++; if (y8 !== 8'h88) begin errors++; $display("FAIL wide_d got %h want 88", y8); end
    checks++; if (sq8 !== 2'b11) begin errors++; $display("FAIL wide_selq got %b want 11", sq8); end
    @(negedge clk);
    drive_sel(2'b00);
    edge_then_sample();
    checks++; if (y8 !== 8'h11) begin errors++; $display("FAIL wide_a got %h want 11", y8); end
    checks++; if (chg8 !== 1'b1) begin errors++; $display("FAIL wide_chg got %b want 1", chg8); end
    @(negedge clk);
    a8 = 8'hA5; b8 = 8'h5A; c8 = 8'h3C;
    drive_sel(2'b10);
    edge_then_sample();
    checks++; if (y8 !== 8'h3C) begin errors++; $display("FAIL wide_c got %h want 3c", y8); end
    @(negedge clk);
    drive_sel(2'b01);
    edge_then_sample();
    checks++; if (y8 !== 8'h5A) begin errors++; $display("FAIL wide_b got %h want 5a", y8); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_first_edge_after_reset();
    test_sweep();
    test_data_toggle();
    test_mid_edge();
    test_async_reset();
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
